aes_buffer_sequencer: RTL

Memory-side sequencer for the AES coprocessor. It walks the 1024-word AES buffer, fetches the 128-bit key and each 128-bit data block, and hands them to the AES round core through a ready/start/done handshake. It writes each result back in place and pulses completion to the MMIO control register. It sits between the control register/shared buffer and the round core, and drives the buffer's AES-side port.

---
 rtl/aes_buffer_sequencer.sv | 233 +++++++++++++++++++++++
 1 files changed

// File: rtl/aes_buffer_sequencer.sv
// aes_buffer_sequencer
//   Walks the shared AES buffer: loads the 128-bit key and block count, then
//   for each block reads four words, runs the round core through a
//   ready/start/done handshake, and writes the result back in place. A
//   one-cycle completion pulse goes back to the MMIO control register.
//
// Ports
//   clk_in           clock
//   rst_in           asynchronous active-low reset
//   aes_ctrl_in      {valid_result, decrypt, encrypt} from the control register
//   data_in          buffer read data, valid one cycle after its address
//   data_out         buffer write data
//   aes_addr_out     buffer word address
//   aes_mem_we_out   buffer byte write enables (nonzero only while writing back)
//   aes_complete_out one-cycle completion pulse
//   core_key_out     key to the round core
//   core_block_out   input block to the round core
//   core_decrypt_out 1 = decrypt, 0 = encrypt
//   core_start_out   one-cycle start pulse to the round core
//   core_ready_in    round core idle
//   core_done_in     core_result_in valid
//   core_result_in   result block
//   busy_out         high whenever the sequencer is not idle
module aes_buffer_sequencer #(
  parameter int KEY_BASE   = 0,
  parameter int COUNT_ADDR = 4,
  parameter int DATA_BASE  = 8,
  parameter int MAX_BLOCKS = 254
) (
  input  logic         clk_in,
  input  logic         rst_in,
  input  logic [2:0]   aes_ctrl_in,
  input  logic [31:0]  data_in,
  output logic [31:0]  data_out,
  output logic [9:0]   aes_addr_out,
  output logic [3:0]   aes_mem_we_out,
  output logic         aes_complete_out,
  output logic [127:0] core_key_out,
  output logic [127:0] core_block_out,
  output logic         core_decrypt_out,
  output logic         core_start_out,
  input  logic         core_ready_in,
  input  logic         core_done_in,
  input  logic [127:0] core_result_in,
  output logic         busy_out
);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHECK, S_READ, S_START, S_WAIT, S_WRITE, S_DONE
  } state_t;

  state_t       state;
  logic [2:0]   sub_cnt;    // step within LOAD / READ / WRITE
  logic [7:0]   count_raw;
  logic [7:0]   n_blocks;
  logic [7:0]   blk_idx;
  logic [127:0] result;

  logic go;
  logic both;
  logic abort;

  assign go    = aes_ctrl_in[0] ^ aes_ctrl_in[1];
  assign both  = aes_ctrl_in[0] & aes_ctrl_in[1];
  assign abort = (aes_ctrl_in[1:0] == 2'b00);

  // Saturate the requested block count so the last data word stays in range.
  function automatic logic [7:0] clamp_count(input logic [7:0] c);
    if (int'(c) > MAX_BLOCKS) return 8'(MAX_BLOCKS);
    return c;
  endfunction

  function automatic logic [9:0] blk_addr(input logic [7:0] idx, input logic [1:0] k);
    return 10'(DATA_BASE) + {idx, 2'b00} + {8'd0, k};
  endfunction

  // Word 0 (lowest address) is the most significant word.
  function automatic logic [31:0] word_of(input logic [127:0] b, input logic [1:0] k);
    logic [31:0] w;
    case (k)
      2'd0:    w = b[127:96];
      2'd1:    w = b[95:64];
      2'd2:    w = b[63:32];
      default: w = b[31:0];
    endcase
    return w;
  endfunction

  // Start is qualified by the live ready input so it fires in the very cycle
  // the core reports idle; an abort in that cycle suppresses it.
  assign core_start_out = (state == S_START) && core_ready_in && !abort;
  assign busy_out       = (state != S_IDLE);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state            <= S_IDLE;
      sub_cnt          <= 3'd0;
      count_raw        <= 8'd0;
      n_blocks         <= 8'd0;
      blk_idx          <= 8'd0;
      result           <= '0;
      aes_addr_out     <= 10'd0;
      data_out         <= 32'd0;
      aes_mem_we_out   <= 4'd0;
      aes_complete_out <= 1'b0;
      core_decrypt_out <= 1'b0;
      core_key_out     <= '0;
      core_block_out   <= '0;
    end else begin
      aes_complete_out <= 1'b0;
      if (abort && state != S_IDLE && state != S_DONE) begin
        state          <= S_IDLE;
        aes_mem_we_out <= 4'd0;
      end else begin
        case (state)
          S_IDLE: begin
            if (both) begin
              state            <= S_DONE;
              aes_complete_out <= 1'b1;
            end else if (go) begin
              core_decrypt_out <= aes_ctrl_in[1];
              state            <= S_LOAD;
              sub_cnt          <= 3'd0;
              aes_addr_out     <= 10'(KEY_BASE);
            end
          end

          // ---- LOAD: addresses on steps 0-4, data captured on steps 1-5
          S_LOAD: begin
            sub_cnt <= sub_cnt + 3'd1;
            case (sub_cnt)
              3'd0: aes_addr_out <= 10'(KEY_BASE + 1);
              3'd1: begin
                core_key_out[127:96] <= data_in;
                aes_addr_out         <= 10'(KEY_BASE + 2);
              end
              3'd2: begin
                core_key_out[95:64] <= data_in;
                aes_addr_out        <= 10'(KEY_BASE + 3);
              end
              3'd3: begin
                core_key_out[63:32] <= data_in;
                aes_addr_out        <= 10'(COUNT_ADDR);
              end
              3'd4: core_key_out[31:0] <= data_in;
              3'd5: begin
                count_raw <= data_in[7:0];
                state     <= S_CHECK;
              end
              default: ;
            endcase
          end

          S_CHECK: begin
            n_blocks <= clamp_count(count_raw);
            blk_idx  <= 8'd0;
            if (clamp_count(count_raw) == 8'd0) begin
              state            <= S_DONE;
              aes_complete_out <= 1'b1;
            end else begin
              state        <= S_READ;
              sub_cnt      <= 3'd0;
              aes_addr_out <= blk_addr(8'd0, 2'd0);
            end
          end

          // ---- READ: addresses on steps 0-3, data captured on steps 1-4
          S_READ: begin
            sub_cnt <= sub_cnt + 3'd1;
            case (sub_cnt)
              3'd0: aes_addr_out <= blk_addr(blk_idx, 2'd1);
              3'd1: begin
                core_block_out[127:96] <= data_in;
                aes_addr_out           <= blk_addr(blk_idx, 2'd2);
              end
              3'd2: begin
                core_block_out[95:64] <= data_in;
                aes_addr_out          <= blk_addr(blk_idx, 2'd3);
              end
              3'd3: core_block_out[63:32] <= data_in;
              3'd4: begin
                core_block_out[31:0] <= data_in;
                state                <= S_START;
              end
              default: ;
            endcase
          end

          S_START: begin
            if (core_ready_in) state <= S_WAIT;
          end

          // ---- WAIT: first write word is presented as the result lands
          S_WAIT: begin
            if (core_done_in) begin
              result         <= core_result_in;
              state          <= S_WRITE;
              sub_cnt        <= 3'd0;
              aes_mem_we_out <= 4'hF;
              aes_addr_out   <= blk_addr(blk_idx, 2'd0);
              data_out       <= core_result_in[127:96];
            end
          end

          // ---- WRITE: four write cycles, then next block or done
          S_WRITE: begin
            sub_cnt <= sub_cnt + 3'd1;
            if (sub_cnt < 3'd3) begin
              aes_addr_out <= blk_addr(blk_idx, sub_cnt[1:0] + 2'd1);
              data_out     <= word_of(result, sub_cnt[1:0] + 2'd1);
            end else begin
              aes_mem_we_out <= 4'd0;
              blk_idx        <= blk_idx + 8'd1;
              if ((blk_idx + 8'd1) == n_blocks) begin
                state            <= S_DONE;
                aes_complete_out <= 1'b1;
              end else begin
                state        <= S_READ;
                sub_cnt      <= 3'd0;
                aes_addr_out <= blk_addr(blk_idx + 8'd1, 2'd0);
              end
            end
          end

          S_DONE: state <= S_IDLE;

          default: state <= S_IDLE;
        endcase
      end
    end
  end

endmodule
